// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter and sequencer in front of a single-port memory.
// Each grant runs IDLE -> ACCESS -> DONE: one mem_en_o pulse, then a one-cycle ack.
module mem_arbiter #(
   parameter int WORD_SIZE = 32,
   parameter int MEM_SIZE  = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 if_req_i,
   input  logic [WORD_SIZE-1:0] if_addr_i,
   output logic                 if_ack_o,
   output logic [WORD_SIZE-1:0] if_rdata_o,
   output logic                 if_err_o,
   input  logic                 d_req_i,
   input  logic                 d_we_i,
   input  logic [WORD_SIZE-1:0] d_addr_i,
   input  logic [WORD_SIZE-1:0] d_wdata_i,
   output logic                 d_ack_o,
   output logic [WORD_SIZE-1:0] d_rdata_o,
   output logic                 d_err_o,
   output logic                 mem_en_o,
   output logic                 mem_read_o,
   output logic                 mem_write_o,
   output logic [WORD_SIZE-1:0] mem_addr_base_o,
   output logic [WORD_SIZE-1:0] mem_addr_offset_o,
   output logic [WORD_SIZE-1:0] mem_wdata_o,
   input  logic [WORD_SIZE-1:0] mem_rdata_i,
   output logic                 busy_o,
   output logic                 grant_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_last_grant;
   logic                   r_err;
   logic                   r_grant;
   logic                   r_read;
   logic                   r_write;
   logic [WORD_SIZE-1:0]   r_addr;
   logic [WORD_SIZE-1:0]   r_wdata;
   logic                   r_if_ack;
   logic                   r_if_err;
   logic [WORD_SIZE-1:0]   r_if_rdata;
   logic                   r_d_ack;
   logic                   r_d_err;
   logic [WORD_SIZE-1:0]   r_d_rdata;
   logic                   w_any_req;
   logic                   w_sel_data;
   logic [WORD_SIZE-1:0]   w_addr;
   logic [WORD_SIZE-1:0]   w_cap_data;

   // On a tie the data port wins only if fetch was served last.
   always_comb begin
      w_any_req  = if_req_i | d_req_i;
      w_sel_data = d_req_i & (~if_req_i | ~r_last_grant);
      w_addr     = w_sel_data ? d_addr_i : if_addr_i;
      w_cap_data = (r_err | r_write) ? '0 : mem_rdata_i;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req) w_next = S_ACCESS;
         S_ACCESS: w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last_grant <= 1'b1;
         r_err        <= 1'b0;
         r_grant      <= 1'b0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_if_ack     <= 1'b0;
         r_if_err     <= 1'b0;
         r_if_rdata   <= '0;
         r_d_ack      <= 1'b0;
         r_d_err      <= 1'b0;
         r_d_rdata    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant      <= w_sel_data;
                  r_last_grant <= w_sel_data;
                  r_addr       <= w_addr;
                  r_read       <= w_sel_data ? ~d_we_i : 1'b1;
                  r_write      <= w_sel_data ? d_we_i : 1'b0;
                  r_wdata      <= w_sel_data ? d_wdata_i : '0;
                  r_err        <= (w_addr >= WORD_SIZE'(MEM_SIZE));
               end
            end
            // Result registers load on the edge ending ACCESS so they are valid in DONE.
            S_ACCESS: begin
               if (r_grant) begin
                  r_d_ack   <= 1'b1;
                  r_d_err   <= r_err;
                  r_d_rdata <= w_cap_data;
               end else begin
                  r_if_ack   <= 1'b1;
                  r_if_err   <= r_err;
                  r_if_rdata <= w_cap_data;
               end
            end
            S_DONE: begin
               r_if_ack   <= 1'b0;
               r_if_err   <= 1'b0;
               r_if_rdata <= '0;
               r_d_ack    <= 1'b0;
               r_d_err    <= 1'b0;
               r_d_rdata  <= '0;
               r_read     <= 1'b0;
               r_write    <= 1'b0;
               r_addr     <= '0;
               r_wdata    <= '0;
               r_err      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign mem_en_o          = (r_state == S_ACCESS) & ~r_err;
   assign mem_read_o        = r_read;
   assign mem_write_o       = r_write;
   assign mem_addr_base_o   = r_addr;
   assign mem_addr_offset_o = '0;
   assign mem_wdata_o       = r_wdata;
   assign busy_o            = (r_state != S_IDLE);
   assign grant_o           = r_grant;
   assign if_ack_o          = r_if_ack;
   assign if_err_o          = r_if_err;
   assign if_rdata_o        = r_if_rdata;
   assign d_ack_o           = r_d_ack;
   assign d_err_o           = r_d_err;
   assign d_rdata_o         = r_d_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port `memory` block. It shares the memory between the instruction-fetch port (read-only) and the data port (load/store) of the core. It converts each granted request into exactly one `en_mem` rising edge, and returns read data with a one-cycle acknowledge. Ties are resolved round-robin, and out-of-range addresses are rejected without touching memory.

## Interface
Parameters:
- WORD_SIZE, 32, data and address width
- MEM_SIZE, 1024, number of memory words; legal word addresses are 0..MEM_SIZE-1

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_req_i  in  1  fetch request; held high until if_ack_o
- if_addr_i  in  WORD_SIZE  fetch word address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  WORD_SIZE  fetch data, valid while if_ack_o
- if_err_o  out  1  out-of-range flag, valid while if_ack_o
- d_req_i  in  1  data request; held high until d_ack_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  WORD_SIZE  data word address
- d_wdata_i  in  WORD_SIZE  store data
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  WORD_SIZE  load data, valid while d_ack_o (0 for stores)
- d_err_o  out  1  out-of-range flag, valid while d_ack_o
- mem_en_o  out  1  to memory en_mem_i; high for exactly one cycle per access
- mem_read_o  out  1  to memory mem_read_i
- mem_write_o  out  1  to memory mem_write_i
- mem_addr_base_o  out  WORD_SIZE  granted address
- mem_addr_offset_o  out  WORD_SIZE  tied to 0
- mem_wdata_o  out  WORD_SIZE  to memory val_i
- mem_rdata_i  in  WORD_SIZE  from memory val_o
- busy_o  out  1  high in ACCESS and DONE
- grant_o  out  1  port in service (0 = fetch, 1 = data); meaningful while busy_o

## Operation
- FSM has three states: IDLE, ACCESS and DONE. Reset state is IDLE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port opposite `last_grant`.
  - On a grant: register grant_o, the address, mem_read_o/mem_write_o (fetch is always a read; data uses d_we_i), and mem_wdata_o (fetch drives 0). Update `last_grant` and go to ACCESS.
- Range check is done at grant: address ≥ MEM_SIZE sets an internal `err` bit.
- ACCESS:
  - mem_en_o = !err. An erroneous request never pulses memory.
  - Always go to DONE.
- DONE:
  - mem_en_o = 0.
  - Capture mem_rdata_i into the granted port's rdata output. Capture 0 if err or store.
  - Assert the granted port's ack for this cycle only, with its err flag = err.
  - Go to IDLE.
- mem_addr_base_o, mem_read_o, mem_write_o and mem_wdata_o stay stable from grant through DONE. They are cleared to 0 on entry to IDLE.
- mem_en_o is never high in two consecutive cycles, so every access produces a fresh rising edge at the memory.
- The non-granted port's ack, rdata and err stay 0. Its request stays pending and is served in the next IDLE.
- Reset (any state, including mid-ACCESS or DONE):
  - Next cycle is IDLE; the in-flight access is dropped with no ack.
  - All outputs are 0; `last_grant` = 1, so fetch wins the first tie.

## Timing
- Request seen high in IDLE at edge t:
  - mem_en_o high in cycle t+1 (ACCESS).
  - ack and rdata valid in cycle t+2 (DONE).
  - FSM back in IDLE at t+3.
- Service time is 3 cycles per access. Peak throughput is one access per 3 cycles.
- Memory read data must be settled by the edge ending ACCESS. Memory acts on the mem_en_o rising edge early in ACCESS.
- A requester samples ack at the edge ending DONE and must drop or replace its request by the following IDLE cycle. A request still high in IDLE is treated as a new access.
- Request inputs are sampled only in IDLE. Changes during ACCESS or DONE are ignored.
- Under continuous contention, grants alternate strictly: fetch, data, fetch, …
- Output reset values are all 0: every ack, err, rdata, mem_* output, busy_o and grant_o.

## Test plan
- Single fetch: preload word 5 = 0xDEADBEEF, if_req_i=1 with if_addr_i=5 → mem_en_o high exactly one cycle at t+1, if_ack_o at t+2, if_rdata_o=0xDEADBEEF, if_err_o=0, d_ack_o stays 0.
- Store then load: d_we_i=1 with d_addr_i=10 and d_wdata_i=0x12345678; then load address 10 → first d_ack_o with d_rdata_o=0, second d_ack_o with d_rdata_o=0x12345678; two mem_en_o pulses total.
- Contention: both requests held high from reset for 12 cycles → grants alternate fetch, data, fetch, data; 4 acks total, each exactly 3 cycles apart.
- Out of range: d_addr_i=1024 with MEM_SIZE=1024 (load) → no mem_en_o pulse, d_ack_o at t+2 with d_err_o=1 and d_rdata_o=0; memory contents unchanged.
- Reset mid-access: assert rst_i during ACCESS of a fetch → no if_ack_o, all outputs 0 next cycle; after release the held request completes normally with one fresh mem_en_o pulse.
- Late request: d_req_i rises during ACCESS of a fetch → fetch completes, data is granted in the next IDLE; d_ack_o arrives 3 cycles after if_ack_o.
